// File: rtl/piso_pkg.sv
// Shared definitions for the PISO transmit shifter: FSM state encodings and
// the bit-counter width helper.
package piso_pkg;

    // Transmitter FSM states; ST_PARITY is only entered when PARITY_TX_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } piso_state_e;

    // Bits needed to hold a count running 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the PISO shifter: tracks which bit of the current
// word is on sout (1..WIDTH), 0 when idle. Flags the final data bit.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load_one,
    input  logic incr,
    output logic last_bit_c
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic [CNT_W-1:0] count;

    // Clear wins over load, load wins over increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load_one) begin
            count <= CNT_W'(1);
        end else if (incr) begin
            count <= count + CNT_W'(1);
        end
    end

    // The bit shown while count equals WIDTH is the last data bit of the word.
    assign last_bit_c = (count == CNT_W'(WIDTH));

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmit shifter. Accepts a WIDTH-bit word on a
// valid/ready handshake and emits it one bit per clock on sout, with gapless
// back-to-back words accepted during the final bit cycle.
// Optional feature macro: PARITY_TX_EN appends one even-parity bit per word.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    piso_state_e      state;
    logic [WIDTH-1:0] shreg;
    logic             last_bit_c;
    logic             accept_c;
    logic             cnt_clear_c;
    logic             cnt_load_c;
    logic             cnt_incr_c;
    logic             first_bit_c;
    logic             next_bit_c;
    logic [WIDTH-1:0] load_shift_c;
    logic [WIDTH-1:0] step_shift_c;
`ifdef PARITY_TX_EN
    logic             parity;
`endif

    // Word-end cycle (last data bit, or parity bit) drives done and reopens the handshake.
    always_comb begin
        done       = 1'b0;
        load_ready = 1'b0;
`ifdef PARITY_TX_EN
        done       = (state == ST_PARITY);
`else
        done       = (state == ST_SHIFT) && last_bit_c;
`endif
        load_ready = rst && ((state == ST_IDLE) || done);
    end

    assign accept_c = load_valid && load_ready;
    assign busy     = sout_valid;

    // Shift direction: pick the outgoing bit and the shifted remainder.
    always_comb begin
        first_bit_c  = 1'b0;
        next_bit_c   = 1'b0;
        load_shift_c = '0;
        step_shift_c = '0;
        if (LSB_FIRST) begin
            first_bit_c  = data_in[0];
            load_shift_c = data_in >> 1;
            next_bit_c   = shreg[0];
            step_shift_c = shreg >> 1;
        end else begin
            first_bit_c  = data_in[WIDTH-1];
            load_shift_c = data_in << 1;
            next_bit_c   = shreg[WIDTH-1];
            step_shift_c = shreg << 1;
        end
    end

    // Bit counter controls: restart on accept, advance mid-word, clear on return to idle.
    always_comb begin
        cnt_clear_c = 1'b0;
        cnt_load_c  = 1'b0;
        cnt_incr_c  = 1'b0;
        if (accept_c) begin
            cnt_load_c = 1'b1;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (!last_bit_c) begin
                        cnt_incr_c = 1'b1;
                    end else begin
`ifdef PARITY_TX_EN
                        cnt_clear_c = 1'b0;
`else
                        cnt_clear_c = 1'b1;
`endif
                    end
                end
`ifdef PARITY_TX_EN
                ST_PARITY: cnt_clear_c = 1'b1;
`endif
                default: cnt_clear_c = 1'b0;
            endcase
        end
    end

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear_c),
        .load_one   (cnt_load_c),
        .incr       (cnt_incr_c),
        .last_bit_c (last_bit_c)
    );

    // FSM, shift register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
`ifdef PARITY_TX_EN
            parity     <= 1'b0;
`endif
        end else if (accept_c) begin
            state      <= ST_SHIFT;
            shreg      <= load_shift_c;
            sout       <= first_bit_c;
            sout_valid <= 1'b1;
`ifdef PARITY_TX_EN
            parity     <= ^data_in;
`endif
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (!last_bit_c) begin
                        shreg <= step_shift_c;
                        sout  <= next_bit_c;
                    end else begin
`ifdef PARITY_TX_EN
                        state      <= ST_PARITY;
                        sout       <= parity;
                        sout_valid <= 1'b1;
`else
                        state      <= ST_IDLE;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
`endif
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
